// File: rtl/x_rr_sel_4_pkg.sv
// Shared types and constants for the 4-channel round-robin select generator.
package x_rr_sel_4_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef logic [1:0] ch_idx_t;

    localparam ch_idx_t CH_A = 2'd0;
    localparam ch_idx_t CH_B = 2'd1;
    localparam ch_idx_t CH_C = 2'd2;
    localparam ch_idx_t CH_D = 2'd3;

    // Channel after ch in the a->b->c->d->a rotation.
    function automatic ch_idx_t next_ch(input ch_idx_t ch);
        return ch + 2'd1;
    endfunction

endpackage

// File: rtl/x_rr_pick_4.sv
// Combinational rotating priority encoder: first requester at or after ptr wins.
module x_rr_pick_4
    import x_rr_sel_4_pkg::*;
(
    input  logic [3:0] req,
    input  ch_idx_t    ptr,
    output ch_idx_t    win,
    output logic       hit
);

    // rot[k] is the request of the channel k positions after ptr.
    logic [3:0] rot;
    ch_idx_t    offs;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot[gi] = req[ptr + 2'(gi)];
        end
    endgenerate

    always_comb begin
        offs = 2'd0;
        if (rot[0])      offs = 2'd0;
        else if (rot[1]) offs = 2'd1;
        else if (rot[2]) offs = 2'd2;
        else if (rot[3]) offs = 2'd3;
    end

    assign hit = |req;
    assign win = ptr + offs;

endmodule

// File: rtl/x_rr_sel_4.sv
// Round-robin select generator driving the index pins of a 4-to-1 mux;
// holds the winning index until ack or timeout, then rotates priority.
module x_rr_sel_4
    import x_rr_sel_4_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_req_c,
    input  logic i_req_d,
    input  logic i_ack,
    output logic o_idx_1,
    output logic o_idx_0,
    output logic o_vld,
    output logic o_timeout
);

    localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e        state_q, state_d;
    ch_idx_t       ptr_q, ptr_d;
    ch_idx_t       idx_q, idx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timeout_q, timeout_d;

    logic [3:0] req_vec;
    ch_idx_t    pick_win;
    logic       pick_hit;

    assign req_vec = {i_req_d, i_req_c, i_req_b, i_req_a};

    x_rr_pick_4 u_pick (
        .req (req_vec),
        .ptr (ptr_q),
        .win (pick_win),
        .hit (pick_hit)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        tcnt_d    = tcnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    idx_d   = pick_win;
                    tcnt_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Ack takes precedence over an expiring timeout.
                if (i_ack) begin
                    ptr_d   = next_ch(idx_q);
                    state_d = IDLE;
                end else if ((TIMEOUT != 0) && (tcnt_q == TCNT_LAST)) begin
                    timeout_d = 1'b1;
                    ptr_d     = next_ch(idx_q);
                    state_d   = IDLE;
                end else if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ptr_q     <= CH_A;
            idx_q     <= CH_A;
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_vld     = (state_q == GRANT);
    assign o_idx_1   = idx_q[1];
    assign o_idx_0   = idx_q[0];
    assign o_timeout = timeout_q;

endmodule
